decode_seq_ctrl: RTL

DECODE_SEQ_CTRL -- requirements
Module: decode_seq_ctrl

---
 rtl/decode_seq_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/decode_seq_ctrl.sv
// Decode sequencing controller: accepts one instruction from fetch, presents it
// to the decoder for a single cycle, then waits for a tagged completion before
// releasing the next instruction. Includes a completion timeout and sticky errors.
module decode_seq_ctrl #(
  parameter int unsigned BUS_WIDTH      = 32,
  parameter int unsigned OPCODE_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_valid,
  input  logic [BUS_WIDTH-1:0]    fetch_instr,
  output logic                    fetch_ready,
  output logic                    instr_valid,
  output logic [BUS_WIDTH-1:0]    instr,
  input  logic [OPCODE_WIDTH-1:0] dec_opcode,
  input  logic                    done_valid,
  input  logic [OPCODE_WIDTH-1:0] op_done,
  output logic                    next_instr,
  input  logic                    flush,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    tag_mismatch,
  output logic [15:0]             instr_count
);

  localparam int unsigned CNT_WIDTH = 16;
  // Last WAIT-cycle counter value before the wait is declared timed out.
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [BUS_WIDTH-1:0]    instr_d;
  logic [OPCODE_WIDTH-1:0] pending_tag;
  logic [OPCODE_WIDTH-1:0] pending_tag_d;
  logic [CNT_WIDTH-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0]    wait_cnt_d;
  logic [CNT_WIDTH-1:0]    instr_count_d;
  logic                    instr_valid_d;
  logic                    next_instr_d;
  logic                    timeout_err_d;
  logic                    tag_mismatch_d;
  logic                    busy_d;
  logic                    tag_hit;

  // Acceptance handshake is combinational so flush can veto it in the same cycle.
  assign fetch_ready = (state == ST_IDLE) && !flush;

  // A completion only counts when it carries the tag latched at issue time.
  assign tag_hit = done_valid && (op_done == pending_tag);

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      instr        <= '0;
      pending_tag  <= '0;
      wait_cnt     <= '0;
      instr_count  <= '0;
      instr_valid  <= 1'b0;
      next_instr   <= 1'b0;
      timeout_err  <= 1'b0;
      tag_mismatch <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      instr        <= instr_d;
      pending_tag  <= pending_tag_d;
      wait_cnt     <= wait_cnt_d;
      instr_count  <= instr_count_d;
      instr_valid  <= instr_valid_d;
      next_instr   <= next_instr_d;
      timeout_err  <= timeout_err_d;
      tag_mismatch <= tag_mismatch_d;
      busy         <= busy_d;
    end
  end

  // Next-state and next-output logic; flush overrides every state.
  always_comb begin
    state_d        = state;
    instr_d        = instr;
    pending_tag_d  = pending_tag;
    wait_cnt_d     = wait_cnt;
    instr_count_d  = instr_count;
    instr_valid_d  = 1'b0;
    next_instr_d   = 1'b0;
    timeout_err_d  = timeout_err;
    tag_mismatch_d = tag_mismatch;

    if (flush) begin
      // Abort: drop any pending work and clear error state; retire count is kept.
      state_d        = ST_IDLE;
      pending_tag_d  = '0;
      wait_cnt_d     = '0;
      timeout_err_d  = 1'b0;
      tag_mismatch_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fetch_valid) begin
            instr_d       = fetch_instr;
            instr_valid_d = 1'b1;
            state_d       = ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          // Decoder output is valid during the single issue cycle.
          pending_tag_d = dec_opcode;
          wait_cnt_d    = '0;
          state_d       = ST_WAIT;
        end

        ST_WAIT: begin
          if (tag_hit) begin
            // A matching completion wins even on the last allowed cycle.
            next_instr_d  = 1'b1;
            instr_count_d = instr_count + CNT_WIDTH'(1);
            wait_cnt_d    = '0;
            state_d       = ST_IDLE;
          end else begin
            if (done_valid) begin
              tag_mismatch_d = 1'b1;
            end
            if (wait_cnt == WAIT_LAST) begin
              timeout_err_d = 1'b1;
              state_d       = ST_ERROR;
            end else begin
              wait_cnt_d = wait_cnt + CNT_WIDTH'(1);
            end
          end
        end

        ST_ERROR: begin
          // Parked until flush or reset.
          state_d = ST_ERROR;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Structural sanity properties on the output protocol.
  a_next_only_idle : assert property (@(posedge clk) disable iff (rst)
    next_instr |-> !busy);
  a_next_one_cycle : assert property (@(posedge clk) disable iff (rst)
    next_instr |=> !next_instr);
  a_issue_is_busy  : assert property (@(posedge clk) disable iff (rst)
    instr_valid |-> busy);
  a_ready_idle     : assert property (@(posedge clk) disable iff (rst)
    fetch_ready |-> !busy);

endmodule
